// File: rtl/triag_pkg.sv
// -----------------------------------------------------------------------------
// triag_pkg
// Shared constants and the state type for the triangle side calculator
// (inverse of the triangle-surface datapath).
//   K_NUM_DEF     : 0.5*sin(56.25 deg) scaled by 2^FRAC_BITS_DEF
//   FRAC_BITS_DEF : fractional shift applied to the surface before division
//   QW_DEF        : quotient (recovered side) width
//   A_W/SURF_W    : operand widths
//   D_W/N_W       : divisor (a*K_NUM) and dividend (surf << FRAC_BITS) widths
// -----------------------------------------------------------------------------
package triag_pkg;

  localparam int K_NUM_DEF     = 54491;
  localparam int FRAC_BITS_DEF = 17;
  localparam int QW_DEF        = 16;

  localparam int A_W    = 16;
  localparam int SURF_W = 32;
  localparam int D_W    = 32;
  localparam int N_W    = 50;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CHECK,
    DIV,
    DONE
  } triag_side_state_t;

endpackage : triag_pkg

// File: rtl/udiv_restoring.sv
// -----------------------------------------------------------------------------
// udiv_restoring
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// The caller guarantees n_i < (d_i << QW), so the quotient fits QW bits and the
// upper N_W-QW dividend bits are already a valid partial remainder (< d_i).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture n_i/d_i and start QW iterations
//   n_i, d_i   : dividend, divisor
//   q_o        : quotient after the current iteration (final while done_o=1)
//   done_o     : high during the last iteration; q_o is the final quotient
// -----------------------------------------------------------------------------
module udiv_restoring #(
  parameter int N_W = 50,
  parameter int D_W = 32,
  parameter int QW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic [N_W-1:0] n_i,
  input  logic [D_W-1:0] d_i,
  output logic [QW-1:0]  q_o,
  output logic           done_o
);

  localparam int R_W  = N_W - QW;
  localparam int RX_W = R_W + 1;
  localparam int CW   = (QW > 1) ? $clog2(QW) : 1;

  logic [R_W-1:0]  rem_q, rem_d;
  logic [RX_W-1:0] rem_sh;
  logic [QW-1:0]   nlo_q;
  logic [QW-1:0]   q_q, q_d;
  logic [D_W-1:0]  d_q;
  logic [CW-1:0]   cnt_q;
  logic            active_q;
  logic            fits;

  // When the divisor fits, the true difference is < d, so computing it modulo
  // 2^R_W loses nothing.
  always_comb begin
    rem_sh = {rem_q, nlo_q[cnt_q]};
    fits   = rem_sh >= RX_W'(d_q);
    rem_d  = fits ? (rem_sh[R_W-1:0] - R_W'(d_q)) : rem_sh[R_W-1:0];
    q_d         = q_q;
    q_d[cnt_q]  = fits;
  end

  assign q_o    = q_d;
  assign done_o = active_q && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      nlo_q    <= '0;
      q_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      // Seed the remainder with the dividend's upper bits; only the low QW
      // bits remain to be shifted in, MSB first.
      rem_q    <= n_i[N_W-1:QW];
      nlo_q    <= n_i[QW-1:0];
      d_q      <= d_i;
      q_q      <= '0;
      cnt_q    <= CW'(QW - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q <= rem_d;
      q_q   <= q_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == '0) active_q <= 1'b0;
    end
  end

endmodule : udiv_restoring

// File: rtl/triag_side_calc.sv
// -----------------------------------------------------------------------------
// triag_side_calc
// Recovers side b from triangle surface and side a under the fixed-angle model
// surf = (a*b*K_NUM) >> FRAC_BITS:  b = floor((surf << FRAC_BITS) / (a*K_NUM)).
// Build option: TRIAG_SIDE_ROUND_EN adds d/2 to the dividend (round to
// nearest); latency is identical either way.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only in IDLE
//   a, surf    : known side, triangle surface (unsigned)
//   busy       : high in every state except IDLE
//   valid      : one-cycle result strobe
//   b          : recovered side, held until the next result
//   err_div0   : a was 0 (qualified by valid)
//   err_ovf    : quotient would not fit QW bits (qualified by valid)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands captured on start
// PREP  | form divisor d = a*K_NUM and dividend n = surf << FRAC_BITS
// CHECK | divide-by-zero / overflow screening, else launch the divider
// DIV   | divider iterating, one quotient bit per clock
// DONE  | result and flags presented, valid high for this cycle
// -----------------------------------------------------------------------------
module triag_side_calc
  import triag_pkg::*;
#(
  parameter int K_NUM     = K_NUM_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int QW        = QW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [A_W-1:0]    a,
  input  logic [SURF_W-1:0] surf,
  output logic              busy,
  output logic              valid,
  output logic [QW-1:0]     b,
  output logic              err_div0,
  output logic              err_ovf
);

  triag_side_state_t state_q;

  logic [A_W-1:0]    a_q;
  logic [SURF_W-1:0] surf_q;
  logic [D_W-1:0]    d_q, d_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [QW-1:0]     b_q;
  logic              err_div0_q, err_ovf_q;
  logic              valid_q, busy_q;

  logic              ovf;
  logic              div_load;
  logic              div_done;
  logic [QW-1:0]     div_q;

  always_comb begin
    d_d = D_W'(a_q) * D_W'(K_NUM);
`ifdef TRIAG_SIDE_ROUND_EN
    n_d = (N_W'(surf_q) << FRAC_BITS) + N_W'(d_d >> 1);
`else
    n_d = N_W'(surf_q) << FRAC_BITS;
`endif
  end

  // Quotient >= 2^QW exactly when n >= d << QW; done at full width so it
  // cannot wrap.
  assign ovf      = n_q >= (N_W'(d_q) << QW);
  assign div_load = (state_q == CHECK) && (a_q != '0) && !ovf;

  udiv_restoring #(
    .N_W (N_W),
    .D_W (D_W),
    .QW  (QW)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (div_load),
    .n_i    (n_q),
    .d_i    (d_q),
    .q_o    (div_q),
    .done_o (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      surf_q     <= '0;
      d_q        <= '0;
      n_q        <= '0;
      b_q        <= '0;
      err_div0_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            surf_q  <= surf;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          d_q     <= d_d;
          n_q     <= n_d;
          state_q <= CHECK;
        end
        CHECK: begin
          if (a_q == '0) begin
            b_q        <= '1;
            err_div0_q <= 1'b1;
            err_ovf_q  <= 1'b0;
            valid_q    <= 1'b1;
            state_q    <= DONE;
          end else if (ovf) begin
            b_q        <= '1;
            err_div0_q <= 1'b0;
            err_ovf_q  <= 1'b1;
            valid_q    <= 1'b1;
            state_q    <= DONE;
          end else begin
            state_q <= DIV;
          end
        end
        DIV: begin
          // div_q already includes this cycle's bit when div_done is high.
          if (div_done) begin
            b_q        <= div_q;
            err_div0_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            valid_q    <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign b        = b_q;
  assign err_div0 = err_div0_q;
  assign err_ovf  = err_ovf_q;

endmodule : triag_side_calc
